// File: rtl/pwm_deadband_gen.sv
// pwm_deadband_gen: turns one PWM waveform into a non-overlapping
// high-side/low-side gate-drive pair. A programmable dead time is inserted
// at every transition. A latched fault forces both outputs low, and
// high-side pulses are counted for software.
module pwm_deadband_gen #(
    parameter int DT_WIDTH   = 8,
    parameter int PCNT_WIDTH = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  pwm_in,
    input  logic                  enable,
    input  logic [DT_WIDTH-1:0]   dt_cycles,
    input  logic                  fault_in,
    input  logic                  fault_clr,
    output logic                  out_hi,
    output logic                  out_lo,
    output logic                  fault_flag,
    output logic [2:0]            state_o,
    output logic [PCNT_WIDTH-1:0] pulse_cnt
);

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_DEAD_R = 3'd1,
        ST_HI     = 3'd2,
        ST_DEAD_F = 3'd3,
        ST_LO     = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                pwm_q;
    logic [DT_WIDTH-1:0] dead_cnt;
    logic [DT_WIDTH-1:0] dead_len;
    logic                dead_done;
    logic                in_dead;
    logic                enter_dead;
    logic                enter_hi;
    logic                out_hi_d;
    logic                out_lo_d;
    logic                fault_flag_d;

    // A programmed dead time of zero still gives one cycle of both-low.
    assign dead_len   = (dt_cycles == '0) ? DT_WIDTH'(1) : dt_cycles;
    // The counter is loaded with D on entry, so the last dead cycle sees 1.
    assign dead_done  = (dead_cnt <= DT_WIDTH'(1));
    assign in_dead    = (state == ST_DEAD_R) || (state == ST_DEAD_F);
    assign enter_dead = ((state_nxt == ST_DEAD_R) || (state_nxt == ST_DEAD_F))
                        && (state_nxt != state);
    assign enter_hi   = (state_nxt == ST_HI) && (state != ST_HI);
    assign state_o    = state;

    // Input stage and state register; the FSM only ever sees pwm_q.
    always_ff @(posedge HCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!HRESETn) begin
            pwm_q <= 1'b0;
            state <= ST_OFF;
        end else begin
            pwm_q <= pwm_in;
            state <= state_nxt;
        end
    end

    // Next-state logic, highest-priority condition first.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_nxt
        // unassigned, which would otherwise infer a latch.
        state_nxt = state;
        if (fault_in) begin
            state_nxt = ST_FAULT;
        end else if (state == ST_FAULT) begin
            if (fault_clr) state_nxt = ST_OFF;
        end else if (!enable) begin
            state_nxt = ST_OFF;
        end else begin
            unique case (state)
                ST_OFF:    state_nxt = pwm_q ? ST_DEAD_R : ST_DEAD_F;
                ST_LO:     if (pwm_q)  state_nxt = ST_DEAD_R;
                ST_HI:     if (!pwm_q) state_nxt = ST_DEAD_F;
                // A pulse that ends inside the dead time is swallowed.
                ST_DEAD_R: if (!pwm_q)        state_nxt = ST_LO;
                           else if (dead_done) state_nxt = ST_HI;
                ST_DEAD_F: if (pwm_q)          state_nxt = ST_HI;
                           else if (dead_done) state_nxt = ST_LO;
                default:   state_nxt = ST_OFF;
            endcase
        end
    end

    // Output decode from the next state, so registered outputs track state.
    always_comb begin
        out_hi_d     = (state_nxt == ST_HI);
        out_lo_d     = (state_nxt == ST_LO);
        fault_flag_d = (state_nxt == ST_FAULT);
    end

    // Dead-time down-counter; dt_cycles is only sampled on entry.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dead_cnt <= '0;
        end else if (enter_dead) begin
            dead_cnt <= dead_len;
        end else if (in_dead && (dead_cnt != '0)) begin
            dead_cnt <= dead_cnt - DT_WIDTH'(1);
        end
    end

    // Registered outputs and the wrapping HI-entry pulse counter.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            out_hi     <= 1'b0;
            out_lo     <= 1'b0;
            fault_flag <= 1'b0;
            pulse_cnt  <= '0;
        end else begin
            out_hi     <= out_hi_d;
            out_lo     <= out_lo_d;
            fault_flag <= fault_flag_d;
            if (enter_hi) pulse_cnt <= pulse_cnt + PCNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pwm_deadband_gen.sv
// Testbench for pwm_deadband_gen: directed scenarios followed by random
// stimulus. A behavioural model predicts each cycle's outputs into a
// scoreboard queue; a separate monitor pops and compares. A second instance
// with a 4-bit pulse counter exposes counter wrap quickly.
module tb_pwm_deadband_gen;

    typedef struct packed {
        logic [2:0]  st;
        logic        hi;
        logic        lo;
        logic        flag;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        pwm_in = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  dt_cycles = 8'd0;
    logic        fault_in = 1'b0;
    logic        fault_clr = 1'b0;

    logic        out_hi, out_lo, fault_flag;
    logic [2:0]  state_o;
    logic [15:0] pulse_cnt;
    logic        out_hi4, out_lo4, fault_flag4;
    logic [2:0]  state_o4;
    logic [3:0]  pulse_cnt4;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    // Model variables: the pwm register, fault latch, whether the driver
    // is active, which side is wanted, dead cycles left, and pulses seen.
    logic        m_q;
    bit          m_fault, m_active, m_side;
    int          m_wait;
    int unsigned m_cnt;

    always #5 HCLK = ~HCLK;

    pwm_deadband_gen #(.DT_WIDTH(8), .PCNT_WIDTH(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .pwm_in(pwm_in), .enable(enable),
        .dt_cycles(dt_cycles), .fault_in(fault_in), .fault_clr(fault_clr),
        .out_hi(out_hi), .out_lo(out_lo), .fault_flag(fault_flag),
        .state_o(state_o), .pulse_cnt(pulse_cnt)
    );

    pwm_deadband_gen #(.DT_WIDTH(8), .PCNT_WIDTH(4)) dut4 (
        .HCLK(HCLK), .HRESETn(HRESETn), .pwm_in(pwm_in), .enable(enable),
        .dt_cycles(dt_cycles), .fault_in(fault_in), .fault_clr(fault_clr),
        .out_hi(out_hi4), .out_lo(out_lo4), .fault_flag(fault_flag4),
        .state_o(state_o4), .pulse_cnt(pulse_cnt4)
    );

    // Advance the model by one clock edge using the inputs present now.
    task automatic model_step();
        logic q_old;
        int   d;
        if (!HRESETn) begin
            m_q = 1'b0; m_fault = 0; m_active = 0; m_side = 0;
            m_wait = 0; m_cnt = 0;
        end else begin
            q_old = m_q;
            d = (dt_cycles == 8'd0) ? 1 : int'(dt_cycles);
            m_q = pwm_in;
            if (fault_in) begin
                m_fault = 1; m_active = 0;
            end else if (m_fault) begin
                if (fault_clr) begin m_fault = 0; m_active = 0; end
            end else if (!enable) begin
                m_active = 0;
            end else if (!m_active) begin
                m_active = 1; m_side = q_old; m_wait = d;
            end else if (m_wait > 0) begin
                if (q_old != m_side) begin
                    m_side = q_old; m_wait = 0;
                    if (q_old) m_cnt++;
                end else begin
                    m_wait--;
                    if (m_wait == 0 && m_side) m_cnt++;
                end
            end else if (q_old != m_side) begin
                m_side = q_old; m_wait = d;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        if (m_fault)           e.st = 3'd5;
        else if (!m_active)    e.st = 3'd0;
        else if (m_wait > 0)   e.st = m_side ? 3'd1 : 3'd3;
        else                   e.st = m_side ? 3'd2 : 3'd4;
        e.hi   = (e.st == 3'd2);
        e.lo   = (e.st == 3'd4);
        e.flag = m_fault;
        e.cnt  = m_cnt[15:0];
        e.cnt4 = m_cnt[3:0];
        return e;
    endfunction

    // One clock: inputs set away from the edge, model pushed at the edge.
    task automatic cycle(input logic rn, input logic p, input logic en,
                         input logic [7:0] dt, input logic fi, input logic fc);
        HRESETn = rn; pwm_in = p; enable = en; dt_cycles = dt;
        fault_in = fi; fault_clr = fc;
        @(posedge HCLK);
        model_step();
        sb_q.push_back(model_out());
        @(negedge HCLK);
    endtask

    task automatic run(input int n, input logic p, input logic en,
                       input logic [7:0] dt, input logic fi, input logic fc);
        for (int i = 0; i < n; i++) cycle(1'b1, p, en, dt, fi, fc);
    endtask

    task automatic check(input exp_t exp, input exp_t got);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL cycle_outputs t=%0t: got st=%0d hi=%b lo=%b flag=%b cnt=%0d cnt4=%0d, expected st=%0d hi=%b lo=%b flag=%b cnt=%0d cnt4=%0d",
                     $time, got.st, got.hi, got.lo, got.flag, got.cnt, got.cnt4,
                     exp.st, exp.hi, exp.lo, exp.flag, exp.cnt, exp.cnt4);
        end
    endtask

    // Monitor: every edge produces one output vector to compare.
    initial begin
        exp_t got;
        forever begin
            @(posedge HCLK);
            #1;
            got = '{st: state_o, hi: out_hi, lo: out_lo, flag: fault_flag,
                    cnt: pulse_cnt, cnt4: pulse_cnt4};
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL scoreboard_empty t=%0t: got an output with no expected entry", $time);
            end else begin
                check(sb_q.pop_front(), got);
            end
        end
    end

    // Stimulus.
    initial begin
        logic p, en, fi, fc, rn;
        logic [7:0] dt;

        // Reset, then enable with dt=4 and pwm low: settles into LO.
        cycle(1'b0, 1'b0, 1'b0, 8'd4, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 8'd4, 1'b0, 1'b0);
        run(8, 1'b0, 1'b1, 8'd4, 1'b0, 1'b0);
        // Rising then falling edge with dt=4.
        run(8, 1'b1, 1'b1, 8'd4, 1'b0, 1'b0);
        run(8, 1'b0, 1'b1, 8'd4, 1'b0, 1'b0);
        // dt=6 with a 3-cycle high pulse: pulse swallowed.
        run(3, 1'b1, 1'b1, 8'd6, 1'b0, 1'b0);
        run(10, 1'b0, 1'b1, 8'd6, 1'b0, 1'b0);
        // dt=0 behaves as one dead cycle per transition.
        for (int i = 0; i < 4; i++) run(3, logic'(i % 2 == 0), 1'b1, 8'd0, 1'b0, 1'b0);
        run(3, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
        // Fault from HI, clear ignored while fault held, then recovery.
        run(6, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0);
        run(1, 1'b1, 1'b1, 8'd2, 1'b1, 1'b0);
        run(2, 1'b1, 1'b1, 8'd2, 1'b1, 1'b1);
        run(2, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0);
        run(1, 1'b1, 1'b1, 8'd2, 1'b0, 1'b1);
        run(6, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0);
        // Enough short pulses to wrap the 4-bit counter.
        for (int i = 0; i < 18; i++) begin
            run(3, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0);
            run(3, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0);
        end
        // Mid-stream one-cycle reset, then disable/re-enable.
        run(4, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0);
        run(5, 1'b1, 1'b1, 8'd3, 1'b0, 1'b0);
        run(3, 1'b1, 1'b0, 8'd3, 1'b0, 1'b0);
        run(6, 1'b1, 1'b1, 8'd3, 1'b0, 1'b0);

        // Random phase.
        p = 1'b0; en = 1'b1; dt = 8'd3;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0)   p  = ~p;
            if ($urandom_range(0, 49) == 0)  en = ~en;
            if ($urandom_range(0, 39) == 0)  dt = 8'($urandom_range(0, 7));
            fi = ($urandom_range(0, 59) == 0);
            fc = ($urandom_range(0, 3) == 0);
            rn = ($urandom_range(0, 499) != 0);
            cycle(rn, p, en, dt, fi, fc);
        end

        #2;
        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
